cv32e40p_guard_ctrl: RTL and testbench
======================================

CV32E40P_GUARD_CTRL -- requirements
Module: cv32e40p_guard_ctrl

Interface
REQ-001 Parameter IDLE_CYCLES, default 4, consecutive idle cycles before operand isolation engages; legal range 1..255.
REQ-002 Parameter WAKE_CYCLES, default 2, settle cycles between isolation release and request acceptance; legal range 1..255.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_valid_i  input  1  operation request to the guarded functional unit.
REQ-006 req_ready_o  output  1  unit accepts the request; handshake when req_valid_i & req_ready_o on the same clk edge.
REQ-007 unit_busy_i  input  1  guarded unit has an operation in flight.
REQ-008 force_on_i  input  1  disables gating (debug/CSR override).
REQ-009 guard_en_o  output  1  enable driven to every guard-eval cell of the unit; 1 = operands pass, 0 = operands isolated (forced 0).
REQ-010 gated_o  output  1  status: unit currently isolated.
REQ-011 gate_count_o  output  16  number of ON->OFF transitions since reset, saturating.

Function
REQ-012 The FSM SHALL have exactly three states: ON, OFF, WAKE; guard_en_o, req_ready_o and gated_o SHALL be decoded from the state register only (Moore, no input-to-output combinational path).
REQ-013 Output decode SHALL be: ON -> guard_en_o=1, req_ready_o=1, gated_o=0; OFF -> 0,0,1; WAKE -> 1,0,0.
REQ-014 An idle cycle SHALL be a cycle in ON with req_valid_i=0, unit_busy_i=0 and force_on_i=0.
REQ-015 In ON, an 8-bit idle counter SHALL increment on each idle cycle and clear to 0 on any non-idle cycle.
REQ-016 In ON, an idle cycle with idle counter == IDLE_CYCLES-1 SHALL move the FSM to OFF at the next edge and clear the idle counter, so guard_en_o falls exactly one cycle after the IDLE_CYCLES-th consecutive idle cycle.
REQ-017 On the ON->OFF transition gate_count_o SHALL increment by 1, saturating at 16'hFFFF with no wrap.
REQ-018 In OFF, req_valid_i=1 or force_on_i=1 or unit_busy_i=1 SHALL move the FSM to WAKE at the next edge with the wake counter cleared; otherwise the FSM stays in OFF.
REQ-019 In WAKE, an 8-bit wake counter SHALL increment each cycle; when it equals WAKE_CYCLES-1 the FSM SHALL move to ON at the next edge, so req_ready_o rises exactly WAKE_CYCLES cycles after entering WAKE.
REQ-020 WAKE SHALL always complete to ON regardless of inputs; deassertion of req_valid_i during WAKE SHALL NOT return the FSM to OFF.
REQ-021 The idle counter SHALL be 0 on entry to ON from WAKE.
REQ-022 A request seen in the same cycle the idle counter would expire SHALL count as non-idle; the FSM stays in ON and the handshake completes that cycle.
REQ-023 force_on_i=1 held continuously SHALL keep the FSM out of OFF indefinitely.
REQ-024 req_valid_i SHALL be held by the requester until handshake; the block SHALL NOT store or drop requests.

Reset
REQ-025 With rst=1 at an edge, the next state SHALL be ON with idle and wake counters 0 and gate_count_o=0, giving guard_en_o=1, req_ready_o=1, gated_o=0.
REQ-026 Reset SHALL take priority over every other transition, including mid-WAKE and the ON->OFF edge.

Verification (IDLE_CYCLES=4, WAKE_CYCLES=2)
REQ-027 Release rst, hold all inputs 0 -> guard_en_o=1 for cycles 1-4, guard_en_o=0 and gated_o=1 from cycle 5, gate_count_o=1.
REQ-028 In OFF, raise req_valid_i at cycle t and hold -> WAKE (guard_en_o=1, req_ready_o=0) at t+1 and t+2, req_ready_o=1 and handshake at t+3.
REQ-029 Three idle cycles, then a 1-cycle req_valid_i with handshake -> stays ON; guard_en_o falls only after 4 further idle cycles.
REQ-030 force_on_i=1 for 100 cycles with no traffic -> guard_en_o stays 1 and gate_count_o stays 0; force_on_i pulse in OFF -> WAKE next cycle, ON two cycles later.
REQ-031 rst=1 during the first WAKE cycle -> next cycle ON with req_ready_o=1 and gate_count_o=0.
REQ-032 IDLE_CYCLES=1, WAKE_CYCLES=1, 65540 gate/wake loops -> gate_count_o reaches 16'hFFFF and holds.

Source files
------------

// File: rtl/cv32e40p_guard_ctrl_if.sv
// Request/guard bundle between a requester and the operand-isolation controller.
// The master side drives requests and overrides; the slave side is the controller.
interface cv32e40p_guard_ctrl_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        unit_busy_i;
  logic        force_on_i;
  logic        guard_en_o;
  logic        gated_o;
  logic [15:0] gate_count_o;

  modport master (
    output req_valid_i, unit_busy_i, force_on_i,
    input  req_ready_o, guard_en_o, gated_o, gate_count_o
  );

  modport slave (
    input  req_valid_i, unit_busy_i, force_on_i,
    output req_ready_o, guard_en_o, gated_o, gate_count_o
  );
endinterface

// File: rtl/cv32e40p_guard_ctrl.sv
// Operand-isolation controller: gates a functional unit after a run of idle
// cycles and brings it back through a fixed settle window before accepting work.
module cv32e40p_guard_ctrl #(
  parameter int unsigned IDLE_CYCLES = 4,
  parameter int unsigned WAKE_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  cv32e40p_guard_ctrl_if.slave       bus
);

  typedef enum logic [1:0] {
    ON   = 2'd0,
    OFF  = 2'd1,
    WAKE = 2'd2
  } state_t;

  localparam logic [7:0] IDLE_LAST = 8'(IDLE_CYCLES - 1);
  localparam logic [7:0] WAKE_LAST = 8'(WAKE_CYCLES - 1);

  state_t      state, nxt;
  logic [7:0]  idle_cnt, idle_nxt;
  logic [7:0]  wake_cnt, wake_nxt;
  logic [15:0] gate_cnt;
  logic        gate_inc;
  logic        is_idle;
  logic        wake_req;
  logic        guard_en, req_ready, gated;

  assign is_idle  = !bus.req_valid_i && !bus.unit_busy_i && !bus.force_on_i;
  assign wake_req =  bus.req_valid_i ||  bus.unit_busy_i ||  bus.force_on_i;

  always_comb begin
    nxt      = state;
    idle_nxt = idle_cnt;
    wake_nxt = wake_cnt;
    gate_inc = 1'b0;
    unique case (state)
      ON: begin
        if (!is_idle) begin
          idle_nxt = 8'd0;
        end else if (idle_cnt == IDLE_LAST) begin
          nxt      = OFF;
          idle_nxt = 8'd0;
          gate_inc = 1'b1;
        end else begin
          idle_nxt = idle_cnt + 8'd1;
        end
      end
      OFF: begin
        if (wake_req) begin
          nxt      = WAKE;
          wake_nxt = 8'd0;
        end
      end
      WAKE: begin
        // The settle window always runs to completion, whatever the inputs do.
        if (wake_cnt == WAKE_LAST) begin
          nxt      = ON;
          wake_nxt = 8'd0;
          idle_nxt = 8'd0;
        end else begin
          wake_nxt = wake_cnt + 8'd1;
        end
      end
      default: begin
        nxt      = ON;
        idle_nxt = 8'd0;
        wake_nxt = 8'd0;
      end
    endcase
  end

  // Outputs are registered from the next state so they always match the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ON;
      idle_cnt  <= 8'd0;
      wake_cnt  <= 8'd0;
      gate_cnt  <= 16'd0;
      guard_en  <= 1'b1;
      req_ready <= 1'b1;
      gated     <= 1'b0;
    end else begin
      state     <= nxt;
      idle_cnt  <= idle_nxt;
      wake_cnt  <= wake_nxt;
      if (gate_inc && (gate_cnt != 16'hFFFF))
        gate_cnt <= gate_cnt + 16'd1;
      guard_en  <= (nxt != OFF);
      req_ready <= (nxt == ON);
      gated     <= (nxt == OFF);
    end
  end

  assign bus.guard_en_o   = guard_en;
  assign bus.req_ready_o  = req_ready;
  assign bus.gated_o      = gated;
  assign bus.gate_count_o = gate_cnt;

endmodule

// File: tb/tb_cv32e40p_guard_ctrl.sv
// Bench for the guard controller: directed vector table, randomized run against a
// cycle model, and a saturation run on a minimal-window instance.
`timescale 1ns/100ps
module tb_cv32e40p_guard_ctrl;

  localparam int IDLE = 4;
  localparam int WAKE = 2;

  logic clk = 1'b0;
  logic clk2 = 1'b0;
  logic rst, rst2;
  always #5 clk = ~clk;
  always #1 clk2 = ~clk2;

  cv32e40p_guard_ctrl_if bus ();
  cv32e40p_guard_ctrl_if bus2 ();

  cv32e40p_guard_ctrl #(.IDLE_CYCLES(IDLE), .WAKE_CYCLES(WAKE)) dut (
    .clk(clk), .rst(rst), .bus(bus));

  cv32e40p_guard_ctrl #(.IDLE_CYCLES(1), .WAKE_CYCLES(1)) dut_sat (
    .clk(clk2), .rst(rst2), .bus(bus2));

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       rst, req, busy, frc;
    logic       en, rdy, gtd;
    logic [15:0] cnt;
  } vec_t;
  vec_t vecs[$];

  function automatic vec_t mk(input logic r, q, b, f, e, y, g, input logic [15:0] c);
    vec_t v;
    v.rst = r; v.req = q; v.busy = b; v.frc = f;
    v.en = e; v.rdy = y; v.gtd = g; v.cnt = c;
    return v;
  endfunction

  // Apply inputs at the falling edge, let one rising edge pass, sample at the next falling edge.
  task automatic cyc(input logic r, q, b, f);
    rst = r; bus.req_valid_i = q; bus.unit_busy_i = b; bus.force_on_i = f;
    @(negedge clk);
  endtask

  task automatic chk_out(input string tag, input logic e, y, g, input logic [15:0] c);
    chk({tag, ".guard_en"},  32'(bus.guard_en_o),   32'(e));
    chk({tag, ".req_ready"}, 32'(bus.req_ready_o),  32'(y));
    chk({tag, ".gated"},     32'(bus.gated_o),      32'(g));
    chk({tag, ".gate_cnt"},  32'(bus.gate_count_o), 32'(c));
  endtask

  // Cycle model written from the behavioural rules: an "off" flag, a count of settle
  // cycles still to go, and the length of the current idle run.
  bit m_off;
  int m_wake_left, m_idle_run, m_cnt;

  function automatic void model_step(input bit r, q, b, f);
    if (r) begin
      m_off = 0; m_wake_left = 0; m_idle_run = 0; m_cnt = 0;
    end else if (m_off) begin
      if (q || b || f) begin m_off = 0; m_wake_left = WAKE; end
    end else if (m_wake_left > 0) begin
      m_wake_left--;
      m_idle_run = 0;
    end else if (!q && !b && !f) begin
      m_idle_run++;
      if (m_idle_run == IDLE) begin
        m_off = 1; m_idle_run = 0;
        if (m_cnt < 65535) m_cnt++;
      end
    end else begin
      m_idle_run = 0;
    end
  endfunction

  initial begin
    rst = 1'b1;
    bus.req_valid_i = 1'b0; bus.unit_busy_i = 1'b0; bus.force_on_i = 1'b0;
    rst2 = 1'b1;
    bus2.req_valid_i = 1'b0; bus2.unit_busy_i = 1'b0; bus2.force_on_i = 1'b0;
    @(negedge clk);

    // rst req busy frc | en rdy gated cnt
    vecs.push_back(mk(1,0,0,0, 1,1,0,0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0,0,0,0, 1,1,0,0));
    vecs.push_back(mk(0,0,0,0, 0,0,1,1));          // 4th idle cycle gates
    vecs.push_back(mk(0,0,0,0, 0,0,1,1));
    vecs.push_back(mk(0,1,0,0, 1,0,0,1));          // request wakes
    vecs.push_back(mk(0,1,0,0, 1,0,0,1));
    vecs.push_back(mk(0,1,0,0, 1,1,0,1));
    vecs.push_back(mk(0,1,0,0, 1,1,0,1));          // handshake
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0,0,0,0, 1,1,0,1));
    vecs.push_back(mk(0,1,0,0, 1,1,0,1));          // request at expiry stays on
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0,0,0,0, 1,1,0,1));
    vecs.push_back(mk(0,0,0,0, 0,0,1,2));
    vecs.push_back(mk(0,0,0,1, 1,0,0,2));          // force pulse wakes
    vecs.push_back(mk(0,0,0,0, 1,0,0,2));          // wake completes without inputs
    vecs.push_back(mk(0,0,0,0, 1,1,0,2));
    vecs.push_back(mk(0,0,1,0, 1,1,0,2));          // busy is not idle
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0,0,0,0, 1,1,0,2));
    vecs.push_back(mk(0,0,0,0, 0,0,1,3));
    vecs.push_back(mk(0,0,1,0, 1,0,0,3));          // busy wakes
    vecs.push_back(mk(1,0,0,0, 1,1,0,0));          // reset mid-wake
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0,0,0,0, 1,1,0,0));
    vecs.push_back(mk(1,0,0,0, 1,1,0,0));          // reset on the gating edge
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0,0,0,0, 1,1,0,0));
    vecs.push_back(mk(0,0,0,0, 0,0,1,1));

    foreach (vecs[i]) begin
      cyc(vecs[i].rst, vecs[i].req, vecs[i].busy, vecs[i].frc);
      chk_out($sformatf("vec%0d", i), vecs[i].en, vecs[i].rdy, vecs[i].gtd, vecs[i].cnt);
    end

    // Held force keeps the unit powered indefinitely.
    cyc(1,0,0,0);
    for (int i = 0; i < 100; i++) begin
      cyc(0,0,0,1);
      chk("force.guard_en", 32'(bus.guard_en_o), 32'd1);
      chk("force.gate_cnt", 32'(bus.gate_count_o), 32'd0);
    end

    // Randomized traffic; a raised request is held until it handshakes.
    begin
      bit q, b, f, r, hs;
      q = 0;
      cyc(1,0,0,0);
      model_step(1,0,0,0);
      for (int i = 0; i < 3000; i++) begin
        r = ($urandom_range(0, 299) == 0);
        if (!q) q = ($urandom_range(0, 9) == 0);
        b = ($urandom_range(0, 11) == 0);
        f = ($urandom_range(0, 29) == 0);
        hs = q && bus.req_ready_o;
        cyc(r, q, b, f);
        model_step(r, q, b, f);
        if (hs || r) q = 0;
        chk_out($sformatf("rnd%0d", i), !m_off, !m_off && (m_wake_left == 0), m_off, 16'(m_cnt));
      end
    end

    // Saturation on the 1/1 instance: each loop is idle (gate), busy (wake), settle.
    @(negedge clk2);
    @(negedge clk2);
    rst2 = 1'b0;
    for (int i = 1; i <= 65540; i++) begin
      bus2.unit_busy_i = 1'b0; @(negedge clk2);
      bus2.unit_busy_i = 1'b1; @(negedge clk2);
      bus2.unit_busy_i = 1'b0; @(negedge clk2);
      if (i == 1000)  chk("sat.cnt1000",  32'(bus2.gate_count_o), 32'd1000);
      if (i == 65534) chk("sat.cnt65534", 32'(bus2.gate_count_o), 32'd65534);
      if (i == 65535) chk("sat.cnt65535", 32'(bus2.gate_count_o), 32'hFFFF);
    end
    chk("sat.hold", 32'(bus2.gate_count_o), 32'hFFFF);
    chk("sat.on",   32'(bus2.req_ready_o),  32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
